// File: rtl/hmc_rf_master_pkg.sv
// Shared types for the openHMC register-file command master: FSM state and
// the latched command / captured response records.
package hmc_rf_master_pkg;

  // Field widths of the command/response records; the master's width
  // parameters default to these so the records line up with its ports.
  localparam int RF_AWIDTH = 4;
  localparam int RF_WWIDTH = 64;
  localparam int RF_RWIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rf_state_t;

  typedef struct packed {
    logic                 write;
    logic [RF_AWIDTH-1:0] address;
    logic [RF_WWIDTH-1:0] wdata;
  } rf_cmd_t;

  typedef struct packed {
    logic                 write;
    logic [RF_RWIDTH-1:0] rdata;
    logic                 invalid;
    logic                 timeout;
  } rf_rsp_t;

endpackage

// File: rtl/hmc_rf_cmd_master.sv
// Single-outstanding register-file initiator: accepts a read/write command,
// strobes the register file once, waits for completion or timeout, returns a response.
module hmc_rf_cmd_master
  import hmc_rf_master_pkg::*;
#(
  parameter int HMC_RF_AWIDTH = RF_AWIDTH,
  parameter int HMC_RF_WWIDTH = RF_WWIDTH,
  parameter int HMC_RF_RWIDTH = RF_RWIDTH,
  parameter int TIMEOUT_LOG   = 8
) (
  input  logic                     clk_hmc,
  input  logic                     res_hmc,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [HMC_RF_AWIDTH-1:0] cmd_address,
  input  logic [HMC_RF_WWIDTH-1:0] cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [HMC_RF_RWIDTH-1:0] rsp_rdata,
  output logic                     rsp_invalid,
  output logic                     rsp_timeout,
  output logic [HMC_RF_AWIDTH-1:0] rf_address,
  output logic                     rf_read_en,
  output logic                     rf_write_en,
  output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
  input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
  input  logic                     rf_invalid_address,
  input  logic                     rf_access_complete,
  output logic                     busy
);

  localparam logic [TIMEOUT_LOG:0] TMO_LIMIT = {1'b1, {TIMEOUT_LOG{1'b0}}};

  rf_state_t              state;
  rf_cmd_t                cmd_p0;
  rf_rsp_t                rsp_p1;
  logic [TIMEOUT_LOG:0]   tmo_cnt;
  logic [TIMEOUT_LOG:0]   tmo_next;

  function automatic rf_rsp_t capture_rsp(input logic                     is_write,
                                          input logic [HMC_RF_RWIDTH-1:0] rdata,
                                          input logic                     invalid);
    rf_rsp_t r;
    r.write   = is_write;
    r.rdata   = is_write ? '0 : rdata;
    r.invalid = invalid;
    r.timeout = 1'b0;
    return r;
  endfunction

  function automatic rf_rsp_t timeout_rsp(input logic is_write);
    rf_rsp_t r;
    r.write   = is_write;
    r.rdata   = '0;
    r.invalid = 1'b0;
    r.timeout = 1'b1;
    return r;
  endfunction

  assign tmo_next = tmo_cnt + 1'b1;

  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      state   <= IDLE;
      cmd_p0  <= '0;
      rsp_p1  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_p0 <= '{write: cmd_write, address: cmd_address, wdata: cmd_wdata};
            state  <= ISSUE;
          end
        end
        // ---- strobe cycle: completion may already arrive here ----
        ISSUE: begin
          tmo_cnt <= '0;
          if (rf_access_complete) begin
            rsp_p1 <= capture_rsp(cmd_p0.write, rf_read_data, rf_invalid_address);
            state  <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        // ---- wait for completion; the counter hits the limit on the abandoning edge ----
        WAIT: begin
          tmo_cnt <= tmo_next;
          if (rf_access_complete) begin
            rsp_p1 <= capture_rsp(cmd_p0.write, rf_read_data, rf_invalid_address);
            state  <= RESP;
          end else if (tmo_next == TMO_LIMIT) begin
            rsp_p1 <= timeout_rsp(cmd_p0.write);
            state  <= RESP;
          end
        end
        // ---- response held until consumed; late completions are ignored ----
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from state plus the latched flag, so both can never be high together.
  assign rf_read_en    = (state == ISSUE) && !cmd_p0.write;
  assign rf_write_en   = (state == ISSUE) &&  cmd_p0.write;
  assign rf_address    = cmd_p0.address;
  assign rf_write_data = cmd_p0.wdata;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_write   = rsp_p1.write;
  assign rsp_rdata   = rsp_p1.rdata;
  assign rsp_invalid = rsp_p1.invalid;
  assign rsp_timeout = rsp_p1.timeout;

endmodule
